// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size codes, FSM encoding and latency limits for dmem_responder
package dmem_pkg;

  // Access size / extension codes; bit 2 marks a sign-extending load
  localparam logic [2:0] SZ_WORD   = 3'b000;
  localparam logic [2:0] SZ_HALF_U = 3'b001;
  localparam logic [2:0] SZ_BYTE_U = 3'b010;
  localparam logic [2:0] SZ_HALF_S = 3'b101;
  localparam logic [2:0] SZ_BYTE_S = 3'b110;

  // Responder FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Legal LATENCY range and the wait-state counter width that covers it
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  // Sign-extending load codes
  function automatic logic is_signed_size(input logic [2:0] size);
    return size[2];
  endfunction

  // Saturating 16-bit increment
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering, load extension and alignment check
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        err
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic        sext;

  // Decode size/offset into lane enables, replicated store data and extended load data
  always_comb begin
    rbyte = rword[{addr, 3'b000} +: 8];
    rhalf = addr[1] ? rword[31:16] : rword[15:0];
    sext  = is_signed_size(size);
    be    = 4'b0000;
    wword = 32'h0;
    rdata = 32'h0;
    err   = 1'b0;
    case (size)
      SZ_WORD: begin
        err   = (addr != 2'b00);
        be    = 4'b1111;
        wword = wdata;
        rdata = rword;
      end
      SZ_HALF_U, SZ_HALF_S: begin
        err   = addr[0];
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = {{16{sext & rhalf[15]}}, rhalf};
      end
      SZ_BYTE_U, SZ_BYTE_S: begin
        be    = 4'b0001 << addr;
        wword = {4{wdata[7:0]}};
        rdata = {{24{sext & rbyte[7]}}, rbyte};
      end
      default: err = 1'b1;
    endcase
    // A faulting access touches no lanes and returns nothing
    if (err) begin
      be    = 4'b0000;
      rdata = 32'h0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated MEM-stage data memory; DMEM_PERF_COUNTERS_EN adds access counters
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
`ifdef DMEM_PERF_COUNTERS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic [15:0]       err_count
`endif
);

  localparam int              WORDS    = 2 ** (ADDR_W - 2);
  localparam bit              SINGLE   = (LATENCY == 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  logic [31:0]       mem [0:WORDS-1];

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [2:0]        cap_size;
  logic [31:0]       cap_wdata;

  logic              accept;
  logic              commit;
  logic              op_write;
  logic [ADDR_W-1:0] op_addr;
  logic [2:0]        op_size;
  logic [31:0]       op_wdata;
  logic [ADDR_W-3:0] widx;
  logic [31:0]       rword;
  logic [3:0]        al_be;
  logic [31:0]       al_wword;
  logic [31:0]       al_rdata;
  logic              al_err;

  assign accept = req_valid & req_ready;

  // With one cycle of latency the access completes on its acceptance edge, so it
  // works from the live request; otherwise it works from the captured copy.
  assign commit   = reset_n & (SINGLE ? accept : ((state == ST_BUSY) && (cnt == CNT_W'(1))));
  assign op_write = SINGLE ? req_write : cap_write;
  assign op_addr  = SINGLE ? req_addr  : cap_addr;
  assign op_size  = SINGLE ? req_size  : cap_size;
  assign op_wdata = SINGLE ? req_wdata : cap_wdata;
  assign widx     = op_addr[ADDR_W-1:2];
  assign rword    = mem[widx];

  dmem_lane_align u_align (
    .size  (op_size),
    .addr  (op_addr[1:0]),
    .wdata (op_wdata),
    .rword (rword),
    .be    (al_be),
    .wword (al_wword),
    .rdata (al_rdata),
    .err   (al_err)
  );

  // Store commit: write only the enabled lanes of a non-faulting store
  always_ff @(posedge clock) begin
    if (commit && op_write && !al_err) begin
      for (int i = 0; i < 4; i++) begin
        if (al_be[i]) begin
          mem[widx][8*i +: 8] <= al_wword[8*i +: 8];
        end
      end
    end
  end

  // Request/response FSM with registered handshake and response outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_size   <= 3'b000;
      cap_wdata  <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      if (commit) begin
        resp_valid <= 1'b1;
        resp_err   <= al_err;
        resp_rdata <= (al_err || op_write) ? 32'h0 : al_rdata;
      end
      case (state)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_size  <= req_size;
            cap_wdata <= req_wdata;
            cnt       <= CNT_LOAD;
            if (SINGLE) begin
              state     <= ST_RESP;
              req_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state     <= ST_BUSY;
              req_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end else begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (cnt == CNT_W'(1)) begin
            state     <= ST_RESP;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMEM_PERF_COUNTERS_EN
  // Count completed accesses on the edge that raises their response pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_count  <= 16'h0;
      wr_count  <= 16'h0;
      err_count <= 16'h0;
    end else if (commit) begin
      if (al_err) begin
        err_count <= sat_inc16(err_count);
      end else if (op_write) begin
        wr_count <= sat_inc16(wr_count);
      end else begin
        rd_count <= sat_inc16(rd_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed vector bench for dmem_responder
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int LAT = 2;

  typedef struct {
    logic        w;
    logic [10:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [10:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata, resp_rdata;
  logic        resp_valid, resp_err, busy;

  logic        v1, rdy1, w1, rv1, re1, bsy1;
  logic [10:0] a1;
  logic [2:0]  sz1;
  logic [31:0] wd1, rd1;

`ifdef DMEM_PERF_COUNTERS_EN
  logic [15:0] rd_cnt, wr_cnt, err_cnt, rd_cnt1, wr_cnt1, err_cnt1;
  int          t_rd, t_wr, t_err;
`endif

  int n_cmp, n_bad;
  vec_t tbl [26];
  vec_t l1  [6];

  always #5 clock = ~clock;

  dmem_responder #(.ADDR_W(11), .LATENCY(LAT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy)
`ifdef DMEM_PERF_COUNTERS_EN
    , .rd_count(rd_cnt), .wr_count(wr_cnt), .err_count(err_cnt)
`endif
  );

  dmem_responder #(.ADDR_W(11), .LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(v1), .req_ready(rdy1), .req_write(w1),
    .req_addr(a1), .req_size(sz1), .req_wdata(wd1),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(re1),
    .busy(bsy1)
`ifdef DMEM_PERF_COUNTERS_EN
    , .rd_count(rd_cnt1), .wr_count(wr_cnt1), .err_count(err_cnt1)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic access(input logic w, input logic [10:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                        input string nm);
    int k;
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz; req_wdata = wd;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    @(posedge clock); #1;
    req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_size = 3'b111; req_wdata = ~wd;
    k = 1;
    while (resp_valid !== 1'b1 && k < 20) begin
      chk({nm, " busy-cycle ready"}, {31'd0, req_ready}, 32'd0);
      chk({nm, " busy-cycle busy"}, {31'd0, busy}, 32'd1);
      @(posedge clock); #1;
      k++;
    end
    chk({nm, " latency"}, 32'(k), 32'(LAT));
    chk({nm, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({nm, " rdata"}, resp_rdata, ed);
    chk({nm, " err"}, {31'd0, resp_err}, {31'd0, ee});
    chk({nm, " resp ready"}, {31'd0, req_ready}, 32'd1);
`ifdef DMEM_PERF_COUNTERS_EN
    if (ee) t_err++; else if (w) t_wr++; else t_rd++;
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
`ifdef DMEM_PERF_COUNTERS_EN
    t_rd = 0; t_wr = 0; t_err = 0;
`endif
    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
    v1 = 1'b0; w1 = 1'b0; a1 = '0; sz1 = '0; wd1 = '0;

    tbl[0]  = '{1'b1, 11'h010, SZ_WORD,   32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 11'h010, SZ_WORD,   32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 11'h020, SZ_WORD,   32'h80FF7F01, 32'h00000000, 1'b0};
    tbl[3]  = '{1'b0, 11'h021, SZ_BYTE_S, 32'h0,        32'h0000007F, 1'b0};
    tbl[4]  = '{1'b0, 11'h023, SZ_BYTE_S, 32'h0,        32'hFFFFFF80, 1'b0};
    tbl[5]  = '{1'b0, 11'h022, SZ_HALF_U, 32'h0,        32'h000080FF, 1'b0};
    tbl[6]  = '{1'b0, 11'h022, SZ_HALF_S, 32'h0,        32'hFFFF80FF, 1'b0};
    tbl[7]  = '{1'b0, 11'h022, SZ_BYTE_U, 32'h0,        32'h000000FF, 1'b0};
    tbl[8]  = '{1'b0, 11'h020, SZ_HALF_S, 32'h0,        32'h00007F01, 1'b0};
    tbl[9]  = '{1'b1, 11'h020, SZ_WORD,   32'h11223344, 32'h00000000, 1'b0};
    tbl[10] = '{1'b1, 11'h022, SZ_BYTE_U, 32'hFFFFFFAB, 32'h00000000, 1'b0};
    tbl[11] = '{1'b0, 11'h020, SZ_WORD,   32'h0,        32'h11AB3344, 1'b0};
    tbl[12] = '{1'b1, 11'h030, SZ_WORD,   32'hCAFEF00D, 32'h00000000, 1'b0};
    tbl[13] = '{1'b1, 11'h031, SZ_HALF_U, 32'h00001234, 32'h00000000, 1'b1};
    tbl[14] = '{1'b1, 11'h032, SZ_WORD,   32'h99999999, 32'h00000000, 1'b1};
    tbl[15] = '{1'b1, 11'h040, SZ_WORD,   32'h0BADC0DE, 32'h00000000, 1'b0};
    tbl[16] = '{1'b1, 11'h040, 3'b011,    32'hFFFFFFFF, 32'h00000000, 1'b1};
    tbl[17] = '{1'b0, 11'h030, SZ_WORD,   32'h0,        32'hCAFEF00D, 1'b0};
    tbl[18] = '{1'b0, 11'h040, SZ_WORD,   32'h0,        32'h0BADC0DE, 1'b0};
    tbl[19] = '{1'b0, 11'h031, SZ_WORD,   32'h0,        32'h00000000, 1'b1};
    tbl[20] = '{1'b0, 11'h030, 3'b111,    32'h0,        32'h00000000, 1'b1};
    tbl[21] = '{1'b1, 11'h036, SZ_HALF_S, 32'h1234BEEF, 32'h00000000, 1'b0};
    tbl[22] = '{1'b0, 11'h036, SZ_HALF_U, 32'h0,        32'h0000BEEF, 1'b0};
    tbl[23] = '{1'b0, 11'h036, SZ_HALF_S, 32'h0,        32'hFFFFBEEF, 1'b0};
    tbl[24] = '{1'b1, 11'h7FC, SZ_WORD,   32'h01020304, 32'h00000000, 1'b0};
    tbl[25] = '{1'b0, 11'h7FF, SZ_BYTE_U, 32'h0,        32'h00000001, 1'b0};

    l1[0] = '{1'b1, 11'h000, SZ_WORD,   32'h11223344, 32'h00000000, 1'b0};
    l1[1] = '{1'b0, 11'h000, SZ_WORD,   32'h0,        32'h11223344, 1'b0};
    l1[2] = '{1'b1, 11'h001, SZ_BYTE_U, 32'h0000005A, 32'h00000000, 1'b0};
    l1[3] = '{1'b0, 11'h000, SZ_WORD,   32'h0,        32'h11225A44, 1'b0};
    l1[4] = '{1'b0, 11'h002, SZ_WORD,   32'h0,        32'h00000000, 1'b1};
    l1[5] = '{1'b0, 11'h001, SZ_BYTE_S, 32'h0,        32'h0000005A, 1'b0};

    repeat (3) @(posedge clock);
    #1;
    chk("reset req_ready",  {31'd0, req_ready},  32'd1);
    chk("reset busy",       {31'd0, busy},       32'd0);
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset resp_rdata", resp_rdata,          32'd0);
    chk("reset resp_err",   {31'd0, resp_err},   32'd0);
    chk("reset l1 ready",   {31'd0, rdy1},       32'd1);
`ifdef DMEM_PERF_COUNTERS_EN
    chk("reset rd_count",  {16'd0, rd_cnt},  32'd0);
    chk("reset wr_count",  {16'd0, wr_cnt},  32'd0);
    chk("reset err_count", {16'd0, err_cnt}, 32'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      access(tbl[i].w, tbl[i].a, tbl[i].sz, tbl[i].wd, tbl[i].ed, tbl[i].ee,
             $sformatf("vec%0d", i));
    end

    // Back-to-back: load held valid through the store, accepted in its RESP cycle
    access(1'b1, 11'h050, SZ_WORD, 32'h0, 32'h0, 1'b0, "b2b init");
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 11'h050; req_size = SZ_BYTE_U; req_wdata = 32'h00000055;
    @(posedge clock); #1;
    req_write = 1'b0; req_size = SZ_WORD; req_wdata = 32'h0;
    chk("b2b store busy ready", {31'd0, req_ready},  32'd0);
    @(posedge clock); #1;
    chk("b2b store resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("b2b store rdata",      resp_rdata,          32'd0);
    chk("b2b store ready",      {31'd0, req_ready},  32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("b2b load busy valid",  {31'd0, resp_valid}, 32'd0);
    chk("b2b load busy ready",  {31'd0, req_ready},  32'd0);
    @(posedge clock); #1;
    chk("b2b load resp_valid",  {31'd0, resp_valid}, 32'd1);
    chk("b2b load rdata",       resp_rdata,          32'h00000055);
    chk("b2b load err",         {31'd0, resp_err},   32'd0);
`ifdef DMEM_PERF_COUNTERS_EN
    t_wr++; t_rd++;
`endif

    // LATENCY=1: a new request every cycle, a response every cycle
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      v1 = 1'b1; w1 = l1[i].w; a1 = l1[i].a; sz1 = l1[i].sz; wd1 = l1[i].wd;
      @(posedge clock); #1;
      chk($sformatf("lat1 vec%0d resp_valid", i), {31'd0, rv1},  32'd1);
      chk($sformatf("lat1 vec%0d rdata", i),      rd1,           l1[i].ed);
      chk($sformatf("lat1 vec%0d err", i),        {31'd0, re1},  {31'd0, l1[i].ee});
      chk($sformatf("lat1 vec%0d ready", i),      {31'd0, rdy1}, 32'd1);
    end
    @(negedge clock);
    v1 = 1'b0;
    @(posedge clock); #1;
    chk("lat1 idle resp_valid", {31'd0, rv1}, 32'd0);

`ifdef DMEM_PERF_COUNTERS_EN
    chk("perf rd_count",  {16'd0, rd_cnt},  32'(t_rd));
    chk("perf wr_count",  {16'd0, wr_cnt},  32'(t_wr));
    chk("perf err_count", {16'd0, err_cnt}, 32'(t_err));
`endif

    // Reset during BUSY of a store drops it entirely
    access(1'b1, 11'h060, SZ_WORD, 32'h0, 32'h0, 1'b0, "rst init");
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 11'h060; req_size = SZ_WORD; req_wdata = 32'h12345678;
    @(posedge clock); #1;
    chk("rst busy before", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    req_valid = 1'b0;
    chk("rst async ready",      {31'd0, req_ready},  32'd1);
    chk("rst async busy",       {31'd0, busy},       32'd0);
    chk("rst async resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst async rdata",      resp_rdata,          32'd0);
    chk("rst async err",        {31'd0, resp_err},   32'd0);
`ifdef DMEM_PERF_COUNTERS_EN
    chk("rst rd_count",  {16'd0, rd_cnt},  32'd0);
    chk("rst wr_count",  {16'd0, wr_cnt},  32'd0);
    chk("rst err_count", {16'd0, err_cnt}, 32'd0);
`endif
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      chk($sformatf("rst hold resp_valid %0d", i), {31'd0, resp_valid}, 32'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("rst release resp_valid", {31'd0, resp_valid}, 32'd0);
    access(1'b0, 11'h060, SZ_WORD, 32'h0, 32'h00000000, 1'b0, "rst readback");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
